// File: rtl/mem_arbiter.sv
// Two-port (core, debug/loader) arbiter in front of one shared memory.
// Each access takes gnt -> ACCESS -> RESP (done) and then returns to IDLE.
// Ports:
//   clk, reset (async, active-low)
//   core_req/we/addr/wdata -> core_gnt/done/rdata
//   dbg_req/we/addr/wdata  -> dbg_gnt/done/rdata
//   mem_a/mem_wd/mem_we to the memory; mem_rd is read back in the same cycle.
// Config: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on contention.
//   The default build uses fixed priority, where dbg beats core.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_done,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e      state_q;
    logic        owner_dbg_q;
    logic        last_dbg_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] core_rdata_q;
    logic [31:0] dbg_rdata_q;
    logic        core_done_q;
    logic        dbg_done_q;
    logic        pick_dbg;

    always_comb begin
        pick_dbg = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        // On contention, favour the port that was not served last.
        pick_dbg = dbg_req && (!core_req || !last_dbg_q);
`else
        // The pointer is still tracked but never steers this choice.
        pick_dbg = dbg_req | (1'b0 & last_dbg_q);
`endif
    end

    assign dbg_gnt  = (state_q == IDLE) && pick_dbg;
    assign core_gnt = (state_q == IDLE) && core_req && !pick_dbg;

    assign mem_a  = (state_q == ACCESS) ? addr_q  : 32'h0;
    assign mem_wd = (state_q == ACCESS) ? wdata_q : 32'h0;
    assign mem_we = (state_q == ACCESS) && we_q;

    assign core_done  = core_done_q;
    assign dbg_done   = dbg_done_q;
    assign core_rdata = core_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_dbg_q  <= 1'b0;
            last_dbg_q   <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            core_rdata_q <= 32'h0;
            dbg_rdata_q  <= 32'h0;
            core_done_q  <= 1'b0;
            dbg_done_q   <= 1'b0;
        end else begin
            core_done_q <= 1'b0;
            dbg_done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (core_gnt || dbg_gnt) begin
                        owner_dbg_q <= pick_dbg;
                        last_dbg_q  <= pick_dbg;
                        we_q        <= pick_dbg ? dbg_we    : core_we;
                        addr_q      <= pick_dbg ? dbg_addr  : core_addr;
                        wdata_q     <= pick_dbg ? dbg_wdata : core_wdata;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner_dbg_q) dbg_rdata_q  <= mem_rd;
                        else             core_rdata_q <= mem_rd;
                    end
                    // Done is registered here so it pulses during RESP.
                    dbg_done_q  <= owner_dbg_q;
                    core_done_q <= !owner_dbg_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
